regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Architectural integer register file (32 x 64-bit) with an issue scoreboard.
- It is the sink for the writeback stage's write port (wen/wdata) and the source for decode-stage operand reads.
- Provides two combinational read ports with same-cycle write bypass.
- Tracks busy destination registers between issue and writeback, and flags writebacks that arrive with no outstanding issue.

Parameters:
XLEN, 64, register data width
NREG, 32, number of architectural registers (x0 hardwired zero)
AW, 5, register address width (log2 NREG)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
w_ena  input  1  writeback write enable (from WB wen)
w_addr  input  AW  writeback destination register
w_data  input  XLEN  writeback data
issue_ena  input  1  instruction with destination issued this cycle
issue_rd  input  AW  destination register of issued instruction
r1_ena  input  1  read port 1 enable
r1_addr  input  AW  read port 1 address
r1_data  output  XLEN  read port 1 data
r1_busy  output  1  read port 1 operand not yet available
r2_ena  input  1  read port 2 enable
r2_addr  input  AW  read port 2 address
r2_data  output  XLEN  read port 2 data
r2_busy  output  1  read port 2 operand not yet available
busy_vec  output  NREG  scoreboard state, bit i = register i busy
err_orphan  output  1  sticky: writeback to a register that was not busy
dbg_addr  input  AW  debug/difftest read address
dbg_data  output  XLEN  debug read data (no bypass)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset effect: all registers, busy_vec and err_orphan cleared to 0 immediately, independent of clk. Reads during reset return 0, busy 0.
- Reset mid-operation: in-flight busy bits are discarded. A w_ena asserted while rst is high is ignored.
- Write:
  - At posedge clk, if w_ena=1 and w_addr!=0, then reg[w_addr] <= w_data.
  - Writes to x0 are dropped. x0 always reads 0.
- Read ports (combinational, zero latency), rN_data:
  - 0 if rN_ena=0 or rN_addr=0;
  - else w_data if w_ena=1 and w_addr==rN_addr (bypass);
  - else reg[rN_addr].
- Busy outputs:
  - rN_busy = rN_ena and rN_addr!=0 and busy_vec[rN_addr] and not (w_ena and w_addr==rN_addr).
  - A same-cycle bypassed write therefore reports not busy.
- Scoreboard update at posedge clk, per register i!=0:
  - set when issue_ena and issue_rd==i;
  - clear when w_ena and w_addr==i;
  - both in the same cycle on the same i: set wins (new producer supersedes retiring one);
  - busy_vec[0] is constantly 0. Issue to x0 has no effect.
  - Issue to an already-busy register: stays busy (single-bit, no count).
- err_orphan:
  - set at posedge when w_ena=1, w_addr!=0 and busy_vec[w_addr]=0 (evaluated on pre-update state).
  - Remains 1 until rst. The write itself still occurs.
- Debug port: dbg_data = reg[dbg_addr] combinationally, architectural state only (no bypass). dbg_addr=0 gives 0.
- Both read ports may address the same register, and the write port in the same cycle; all see identical bypassed data.
- No stalls or backpressure: every write completes in one cycle.

Test Plan:
- Reset: assert rst asynchronously mid-cycle after loading x5=0x1234 → dbg_data(x5)=0, busy_vec=0, err_orphan=0 before next clk edge.
- Write/read: w_ena=1, w_addr=3, w_data=0xDEADBEEF_00000001 for one cycle, then r1_addr=3 → r1_data=0xDEADBEEF_00000001. Same cycle as write, r2_addr=3 → bypassed value, dbg_data still old value 0.
- x0: w_ena=1, w_addr=0, w_data=0xFFFF… → r1_addr=0 gives 0. issue_rd=0 → busy_vec[0]=0. err_orphan stays 0.
- Scoreboard: issue_rd=7 at cycle N → busy_vec[7]=1 from N+1, r1_busy=1 for r1_addr=7. Write x7 at cycle N+3 → r1_busy=0 in N+3 (bypass), busy_vec[7]=0 from N+4. err_orphan=0.
- Simultaneous set/clear: x9 busy; same cycle issue_rd=9 and w_addr=9, w_ena=1 → x9 written, busy_vec[9] remains 1.
- Orphan: with busy_vec=0, write x12 → reg written, err_orphan=1 next cycle and held until rst.

Source files
------------

// File: rtl/regfile_sb_if.sv
// rtl/regfile_sb_if.sv - register file / scoreboard port bundle
interface regfile_sb_if #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int AW   = 5
);
    logic            w_ena;
    logic [AW-1:0]   w_addr;
    logic [XLEN-1:0] w_data;
    logic            issue_ena;
    logic [AW-1:0]   issue_rd;
    logic            r1_ena;
    logic [AW-1:0]   r1_addr;
    logic [XLEN-1:0] r1_data;
    logic            r1_busy;
    logic            r2_ena;
    logic [AW-1:0]   r2_addr;
    logic [XLEN-1:0] r2_data;
    logic            r2_busy;
    logic [NREG-1:0] busy_vec;
    logic            err_orphan;
    logic [AW-1:0]   dbg_addr;
    logic [XLEN-1:0] dbg_data;

    modport master (
        output w_ena, w_addr, w_data, issue_ena, issue_rd,
        output r1_ena, r1_addr, r2_ena, r2_addr, dbg_addr,
        input  r1_data, r1_busy, r2_data, r2_busy, busy_vec, err_orphan, dbg_data
    );

    modport slave (
        input  w_ena, w_addr, w_data, issue_ena, issue_rd,
        input  r1_ena, r1_addr, r2_ena, r2_addr, dbg_addr,
        output r1_data, r1_busy, r2_data, r2_busy, busy_vec, err_orphan, dbg_data
    );
endinterface

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - 32x64 integer register file with write bypass and issue scoreboard
module regfile_sb #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input logic         clk,
    input logic         rst,
    regfile_sb_if.slave bus
);
    logic [XLEN-1:0] r_regs [NREG];
    logic [NREG-1:0] r_busy;
    logic            r_err;

    logic            w_wr;
    logic [NREG-1:0] w_busy_next;
    logic [XLEN-1:0] w_r1_data;
    logic [XLEN-1:0] w_r2_data;
    logic            w_r1_hit;
    logic            w_r2_hit;

    assign w_wr     = bus.w_ena && (bus.w_addr != '0);
    assign w_r1_hit = bus.w_ena && (bus.w_addr == bus.r1_addr);
    assign w_r2_hit = bus.w_ena && (bus.w_addr == bus.r2_addr);

    // Issue is applied after writeback so a new producer supersedes the retiring one.
    always_comb begin
        w_busy_next = r_busy;
        if (bus.w_ena)
            w_busy_next[bus.w_addr] = 1'b0;
        if (bus.issue_ena)
            w_busy_next[bus.issue_rd] = 1'b1;
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                r_regs[i] <= '0;
            r_busy <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_wr) begin
                r_regs[bus.w_addr] <= bus.w_data;
                if (!r_busy[bus.w_addr])
                    r_err <= 1'b1;
            end
            r_busy <= w_busy_next;
        end
    end

    // Entry 0 is never written, so indexing it directly yields the hardwired zero.
    always_comb begin
        w_r1_data = '0;
        if (!rst && bus.r1_ena && bus.r1_addr != '0)
            w_r1_data = w_r1_hit ? bus.w_data : r_regs[bus.r1_addr];
        w_r2_data = '0;
        if (!rst && bus.r2_ena && bus.r2_addr != '0)
            w_r2_data = w_r2_hit ? bus.w_data : r_regs[bus.r2_addr];
    end

    assign bus.r1_data    = w_r1_data;
    assign bus.r2_data    = w_r2_data;
    assign bus.r1_busy    = bus.r1_ena && (bus.r1_addr != '0) && r_busy[bus.r1_addr] && !w_r1_hit;
    assign bus.r2_busy    = bus.r2_ena && (bus.r2_addr != '0) && r_busy[bus.r2_addr] && !w_r2_hit;
    assign bus.busy_vec   = r_busy;
    assign bus.err_orphan = r_err;
    assign bus.dbg_data   = r_regs[bus.dbg_addr];
endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed self-checking bench for regfile_sb
module tb_regfile_sb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    regfile_sb_if #(.XLEN(64), .NREG(32), .AW(5)) bus ();

    regfile_sb #(.XLEN(64), .NREG(32), .AW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.w_ena     = 1'b0;
        bus.issue_ena = 1'b0;
    endtask

    initial begin
        bus.w_ena = 0; bus.w_addr = 0; bus.w_data = 0;
        bus.issue_ena = 0; bus.issue_rd = 0;
        bus.r1_ena = 0; bus.r1_addr = 0; bus.r2_ena = 0; bus.r2_addr = 0;
        bus.dbg_addr = 0;

        #2;
        chk("rst_busy_vec", 64'(bus.busy_vec), 64'h0);
        chk("rst_err", 64'(bus.err_orphan), 64'h0);
        chk("rst_dbg", bus.dbg_data, 64'h0);
        @(negedge clk); rst = 1'b0;

        // load x5 (orphan write), then async reset mid-cycle
        bus.w_ena = 1; bus.w_addr = 5; bus.w_data = 64'h1234;
        @(negedge clk); idle(); bus.dbg_addr = 5; #1;
        chk("x5_loaded", bus.dbg_data, 64'h1234);
        chk("x5_orphan", 64'(bus.err_orphan), 64'h1);
        #1 rst = 1'b1; #1;
        chk("async_rst_dbg", bus.dbg_data, 64'h0);
        chk("async_rst_err", 64'(bus.err_orphan), 64'h0);
        chk("async_rst_busy", 64'(bus.busy_vec), 64'h0);
        bus.w_ena = 1; bus.w_addr = 6; bus.w_data = 64'h55;
        bus.r1_ena = 1; bus.r1_addr = 6; #1;
        chk("rst_read_zero", bus.r1_data, 64'h0);
        @(negedge clk); idle(); bus.r1_ena = 0; bus.dbg_addr = 6; #1;
        chk("write_in_rst_ignored", bus.dbg_data, 64'h0);
        rst = 1'b0;

        // x0 handling
        @(negedge clk);
        bus.w_ena = 1; bus.w_addr = 0; bus.w_data = '1;
        bus.issue_ena = 1; bus.issue_rd = 0;
        bus.r1_ena = 1; bus.r1_addr = 0; #1;
        chk("x0_read_bypass", bus.r1_data, 64'h0);
        @(negedge clk); idle(); bus.dbg_addr = 0; #1;
        chk("x0_busy", 64'(bus.busy_vec), 64'h0);
        chk("x0_err", 64'(bus.err_orphan), 64'h0);
        chk("x0_dbg", bus.dbg_data, 64'h0);

        // issue x3, then write it with bypass on both ports
        bus.issue_ena = 1; bus.issue_rd = 3;
        @(negedge clk); idle();
        bus.r2_ena = 1; bus.r2_addr = 3; #1;
        chk("x3_busy_vec", 64'(bus.busy_vec), 64'h8);
        chk("x3_r2_busy", 64'(bus.r2_busy), 64'h1);
        bus.w_ena = 1; bus.w_addr = 3; bus.w_data = 64'hDEADBEEF_00000001;
        bus.r1_ena = 1; bus.r1_addr = 3; bus.dbg_addr = 3; #1;
        chk("x3_r1_bypass", bus.r1_data, 64'hDEADBEEF_00000001);
        chk("x3_r2_bypass", bus.r2_data, 64'hDEADBEEF_00000001);
        chk("x3_r2_busy_bypass", 64'(bus.r2_busy), 64'h0);
        chk("x3_dbg_old", bus.dbg_data, 64'h0);
        @(negedge clk); idle(); #1;
        chk("x3_r1_read", bus.r1_data, 64'hDEADBEEF_00000001);
        chk("x3_dbg_new", bus.dbg_data, 64'hDEADBEEF_00000001);
        chk("x3_busy_clear", 64'(bus.busy_vec), 64'h0);
        chk("x3_err", 64'(bus.err_orphan), 64'h0);
        bus.r2_ena = 0; #1;
        chk("r2_disabled", bus.r2_data, 64'h0);

        // scoreboard timing on x7
        bus.issue_ena = 1; bus.issue_rd = 7;
        @(negedge clk); idle(); bus.r1_addr = 7; #1;
        chk("x7_busy_vec", 64'(bus.busy_vec), 64'h80);
        chk("x7_r1_busy", 64'(bus.r1_busy), 64'h1);
        @(negedge clk);
        @(negedge clk);
        bus.w_ena = 1; bus.w_addr = 7; bus.w_data = 64'h77; #1;
        chk("x7_r1_busy_bypass", 64'(bus.r1_busy), 64'h0);
        chk("x7_r1_data_bypass", bus.r1_data, 64'h77);
        chk("x7_busy_vec_still", 64'(bus.busy_vec), 64'h80);
        @(negedge clk); idle(); #1;
        chk("x7_busy_clear", 64'(bus.busy_vec), 64'h0);
        chk("x7_err", 64'(bus.err_orphan), 64'h0);

        // simultaneous issue and writeback on x9
        bus.issue_ena = 1; bus.issue_rd = 9;
        @(negedge clk);
        bus.w_ena = 1; bus.w_addr = 9; bus.w_data = 64'h99;
        @(negedge clk); idle(); bus.dbg_addr = 9; #1;
        chk("x9_busy_kept", 64'(bus.busy_vec), 64'h200);
        chk("x9_written", bus.dbg_data, 64'h99);
        chk("x9_err", 64'(bus.err_orphan), 64'h0);

        // retire x9, then orphan write to x12
        bus.w_ena = 1; bus.w_addr = 9; bus.w_data = 64'h9A;
        @(negedge clk); idle(); #1;
        chk("x9_retired_err", 64'(bus.err_orphan), 64'h0);
        chk("x9_retired_busy", 64'(bus.busy_vec), 64'h0);
        bus.w_ena = 1; bus.w_addr = 12; bus.w_data = 64'hC;
        #1 chk("x12_err_before", 64'(bus.err_orphan), 64'h0);
        @(negedge clk); idle(); bus.dbg_addr = 12; #1;
        chk("x12_orphan", 64'(bus.err_orphan), 64'h1);
        chk("x12_written", bus.dbg_data, 64'hC);
        @(negedge clk); @(negedge clk); #1;
        chk("x12_orphan_sticky", 64'(bus.err_orphan), 64'h1);
        #1 rst = 1'b1; #1;
        chk("final_rst_err", 64'(bus.err_orphan), 64'h0);
        chk("final_rst_dbg", bus.dbg_data, 64'h0);
        @(negedge clk); rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
